// File: rtl/block_sync_rx.sv
// Receive block synchroniser: validates 2-bit sync headers, slips the gearbox until aligned, flags block lock.
// Latency: one cycle from head_i/data_i to head_o/data_o/valid_o.
// Backpressure: none; one header is evaluated per valid_i beat, and idle cycles hold all counters.
module block_sync_rx #(
  parameter int HEAD_W       = 2,
  parameter int DATA_W       = 64,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pma_lock_v_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              slip_v_o,
  output logic              lock_v_o,
  output logic              valid_o,
  output logic [HEAD_W-1:0] head_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int SH_CNT_W = $clog2(SH_CNT_MAX + 1);
  localparam int INVLD_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W   = (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);

  localparam logic [SH_CNT_W-1:0] CNT_LAST   = SH_CNT_W'(SH_CNT_MAX);
  localparam logic [INVLD_W-1:0]  INVLD_LAST = INVLD_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_TEST      = 2'd0,
    ST_SLIP      = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [SH_CNT_W-1:0] sh_cnt, sh_cnt_n, sh_cnt_inc;
  logic [INVLD_W-1:0]  sh_invld_cnt, sh_invld_cnt_n, sh_invld_inc;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n, wait_inc;
  logic                lock_n;
  logic                sh_ok;

  // A legal header has exactly one of its two bits set.
  assign sh_ok = head_i[0] ^ head_i[1];

  // The slip pulse is the single cycle spent in SLIP.
  assign slip_v_o = (state == ST_SLIP);

  // Next-state and counter update for the lock state machine.
  always_comb begin
    state_n        = state;
    sh_cnt_n       = sh_cnt;
    sh_invld_cnt_n = sh_invld_cnt;
    wait_cnt_n     = wait_cnt;
    lock_n         = lock_v_o;
    sh_cnt_inc     = sh_cnt + SH_CNT_W'(1);
    sh_invld_inc   = sh_invld_cnt + INVLD_W'(1);
    wait_inc       = wait_cnt + WAIT_W'(1);

    if (!pma_lock_v_i) begin
      // Loss of CDR lock restarts acquisition without asking the gearbox to slip.
      state_n        = ST_TEST;
      sh_cnt_n       = '0;
      sh_invld_cnt_n = '0;
      wait_cnt_n     = '0;
      lock_n         = 1'b0;
    end else begin
      case (state)
        ST_TEST: begin
          if (valid_i) begin
            sh_cnt_n = sh_cnt_inc;
            if (sh_ok) begin
              if (sh_cnt_inc == CNT_LAST) begin
                // A clean full window grants lock; any window end restarts counting.
                if (sh_invld_cnt == '0) lock_n = 1'b1;
                sh_cnt_n       = '0;
                sh_invld_cnt_n = '0;
              end
            end else begin
              sh_invld_cnt_n = sh_invld_inc;
              if (!lock_v_o || (sh_invld_inc == INVLD_LAST)) begin
                // Unlocked: any bad header means misalignment. Locked: too many bad headers.
                lock_n         = 1'b0;
                state_n        = ST_SLIP;
                sh_cnt_n       = '0;
                sh_invld_cnt_n = '0;
              end else if (sh_cnt_inc == CNT_LAST) begin
                sh_cnt_n       = '0;
                sh_invld_cnt_n = '0;
              end
            end
          end
        end
        ST_SLIP: begin
          sh_cnt_n       = '0;
          sh_invld_cnt_n = '0;
          wait_cnt_n     = '0;
          state_n        = ST_SLIP_WAIT;
        end
        ST_SLIP_WAIT: begin
          // Headers during gearbox realignment are meaningless, so only beats are counted.
          if (valid_i) begin
            if (wait_inc == WAIT_LAST) begin
              wait_cnt_n     = '0;
              sh_cnt_n       = '0;
              sh_invld_cnt_n = '0;
              state_n        = ST_TEST;
            end else begin
              wait_cnt_n = wait_inc;
            end
          end
        end
        default: begin
          state_n        = ST_TEST;
          sh_cnt_n       = '0;
          sh_invld_cnt_n = '0;
          wait_cnt_n     = '0;
          lock_n         = 1'b0;
        end
      endcase
    end
  end

  // State, counters, lock flag and the one-cycle forwarding register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_TEST;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      lock_v_o     <= 1'b0;
      valid_o      <= 1'b0;
      head_o       <= '0;
      data_o       <= '0;
    end else begin
      state        <= state_n;
      sh_cnt       <= sh_cnt_n;
      sh_invld_cnt <= sh_invld_cnt_n;
      wait_cnt     <= wait_cnt_n;
      lock_v_o     <= lock_n;
      // Using the next lock value forwards the locking beat and suppresses the dropping one.
      valid_o      <= valid_i & lock_n & pma_lock_v_i;
      if (valid_i) begin
        head_o <= head_i;
        data_o <= data_i;
      end
    end
  end

endmodule

// File: tb/tb_block_sync_rx.sv
// Randomised bench for block_sync_rx against a beat-level reference model of the lock rules.
// Each scenario task drives its own stimulus and checks its own results inline.
// The summary line reports total comparisons and failures.
module tb_block_sync_rx;

  localparam int SH_CNT_MAX   = 64;
  localparam int SH_INVLD_MAX = 16;
  localparam int SLIP_WAIT    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pma = 1'b1;
  logic        vin = 1'b0;
  logic [1:0]  hin = 2'b00;
  logic [63:0] din = '0;
  logic        slip_v_o, lock_v_o, valid_o;
  logic [1:0]  head_o;
  logic [63:0] data_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: window position, bad-header tally, beats still to skip after a slip.
  logic        m_lock, m_slip, m_valid;
  logic [1:0]  m_head;
  logic [63:0] m_data;
  int          m_win, m_bad, m_blind;

  block_sync_rx dut (
    .clk          (clk),
    .reset        (reset),
    .pma_lock_v_i (pma),
    .valid_i      (vin),
    .head_i       (hin),
    .data_i       (din),
    .slip_v_o     (slip_v_o),
    .lock_v_o     (lock_v_o),
    .valid_o      (valid_o),
    .head_o       (head_o),
    .data_o       (data_o)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] legal_head();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] illegal_head();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Advance the model by one clock using the inputs the DUT just sampled.
  task automatic model_update();
    logic was_slip;
    logic legal;
    if (reset) begin
      m_lock = 0; m_slip = 0; m_valid = 0; m_head = '0; m_data = '0;
      m_win = 0; m_bad = 0; m_blind = 0;
    end else if (!pma) begin
      m_lock = 0; m_slip = 0; m_valid = 0;
      m_win = 0; m_bad = 0; m_blind = 0;
      if (vin) begin m_head = hin; m_data = din; end
    end else begin
      was_slip = m_slip;
      m_slip = 0;
      if (was_slip) begin
        m_blind = SLIP_WAIT;
      end else if (vin) begin
        if (m_blind > 0) begin
          m_blind = m_blind - 1;
        end else begin
          legal = (hin == 2'b01) || (hin == 2'b10);
          m_win = m_win + 1;
          if (!legal) m_bad = m_bad + 1;
          if (!legal && (!m_lock || m_bad == SH_INVLD_MAX)) begin
            m_lock = 0; m_slip = 1; m_win = 0; m_bad = 0;
          end else if (m_win == SH_CNT_MAX) begin
            if (m_bad == 0) m_lock = 1;
            m_win = 0; m_bad = 0;
          end
        end
      end
      m_valid = vin && m_lock;
      if (vin) begin m_head = hin; m_data = din; end
    end
  endtask

  // Drive one cycle, update the model at the edge, then settle before any sampling.
  task automatic step(input logic v, input logic [1:0] h, input logic [63:0] d);
    vin = v; hin = h; din = d;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; pma = 1'b1;
    step(0, 2'b00, '0);
    step(0, 2'b00, '0);
    reset = 1'b0;
  endtask

  task automatic do_lock();
    apply_reset();
    for (int i = 0; i < SH_CNT_MAX; i++) step(1, 2'b01, rnd64());
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({slip_v_o, lock_v_o, valid_o, head_o, data_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got slip=%b lock=%b valid=%b head=%b data=%h, want all 0",
               slip_v_o, lock_v_o, valid_o, head_o, data_o);
    end
  endtask

  task automatic test_lock();
    logic [63:0] d;
    apply_reset();
    for (int i = 1; i <= SH_CNT_MAX + 8; i++) begin
      d = rnd64();
      step(1, 2'b01, d);
      total++;
      if (lock_v_o !== (i >= SH_CNT_MAX) || valid_o !== (i >= SH_CNT_MAX) ||
          data_o !== d || slip_v_o !== 1'b0) begin
        bad++;
        $display("FAIL lock_acquire beat %0d: got lock=%b valid=%b slip=%b data=%h, want lock=%b valid=%b slip=0 data=%h",
                 i, lock_v_o, valid_o, slip_v_o, data_o, i >= SH_CNT_MAX, i >= SH_CNT_MAX, d);
      end
    end
  endtask

  task automatic test_slip();
    int slips = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) step(1, legal_head(), rnd64());
    step(1, illegal_head(), rnd64());
    total++;
    if (slip_v_o !== 1'b1 || lock_v_o !== 1'b0) begin
      bad++;
      $display("FAIL slip_pulse: got slip=%b lock=%b, want slip=1 lock=0", slip_v_o, lock_v_o);
    end
    // The beat in the slip cycle and the two realignment beats are all illegal and must be ignored.
    for (int i = 0; i < SLIP_WAIT + 1; i++) begin
      step(1, illegal_head(), rnd64());
      if (slip_v_o) slips++;
    end
    for (int i = 1; i <= SH_CNT_MAX; i++) begin
      step(1, legal_head(), rnd64());
      if (slip_v_o) slips++;
      total++;
      if (lock_v_o !== (i == SH_CNT_MAX) || lock_v_o !== m_lock) begin
        bad++;
        $display("FAIL slip_relock beat %0d: got lock=%b, want %b", i, lock_v_o, i == SH_CNT_MAX);
      end
    end
    total++;
    if (slips != 0) begin
      bad++;
      $display("FAIL slip_single: got %0d extra slip cycles, want 0", slips);
    end
  endtask

  task automatic test_window();
    logic [63:0] mask;
    int          nbad;
    logic        isbad;
    do_lock();
    mask = '0;
    while ($countones(mask) < SH_INVLD_MAX - 1) mask[$urandom_range(0, 63)] = 1'b1;
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      step(1, mask[i] ? illegal_head() : legal_head(), rnd64());
      total++;
      if (lock_v_o !== 1'b1 || slip_v_o !== 1'b0 || valid_o !== 1'b1) begin
        bad++;
        $display("FAIL window_15_bad pos %0d: got lock=%b slip=%b valid=%b, want 1 0 1",
                 i, lock_v_o, slip_v_o, valid_o);
      end
    end
    mask = '0;
    while ($countones(mask) < SH_INVLD_MAX) mask[$urandom_range(0, 63)] = 1'b1;
    nbad = 0;
    for (int i = 0; i < SH_CNT_MAX; i++) begin
      isbad = mask[i];
      step(1, isbad ? illegal_head() : legal_head(), rnd64());
      if (isbad) nbad++;
      total++;
      if (nbad == SH_INVLD_MAX) begin
        if (lock_v_o !== 1'b0 || slip_v_o !== 1'b1 || valid_o !== 1'b0) begin
          bad++;
          $display("FAIL window_16th_bad pos %0d: got lock=%b slip=%b valid=%b, want 0 1 0",
                   i, lock_v_o, slip_v_o, valid_o);
        end
        break;
      end else if (lock_v_o !== 1'b1 || slip_v_o !== 1'b0) begin
        bad++;
        $display("FAIL window_pre16 pos %0d: got lock=%b slip=%b, want 1 0", i, lock_v_o, slip_v_o);
      end
    end
  endtask

  task automatic test_pma();
    do_lock();
    pma = 1'b0;
    step(1, 2'b01, rnd64());
    pma = 1'b1;
    total++;
    if (lock_v_o !== 1'b0 || valid_o !== 1'b0 || slip_v_o !== 1'b0) begin
      bad++;
      $display("FAIL pma_drop: got lock=%b valid=%b slip=%b, want 0 0 0", lock_v_o, valid_o, slip_v_o);
    end
    for (int i = 1; i <= SH_CNT_MAX; i++) begin
      step(1, legal_head(), rnd64());
      total++;
      if (lock_v_o !== (i == SH_CNT_MAX) || slip_v_o !== 1'b0) begin
        bad++;
        $display("FAIL pma_relock beat %0d: got lock=%b slip=%b, want lock=%b slip=0",
                 i, lock_v_o, slip_v_o, i == SH_CNT_MAX);
      end
    end
  endtask

  task automatic test_toggle();
    int n = 0;
    logic v;
    apply_reset();
    for (int c = 0; c < 400 && n < SH_CNT_MAX; c++) begin
      v = (c % 2 == 0) || ($urandom_range(0, 3) == 0);
      step(v, legal_head(), rnd64());
      if (v) n++;
      total++;
      if (lock_v_o !== (n == SH_CNT_MAX) || valid_o !== (v && n == SH_CNT_MAX) || data_o !== m_data) begin
        bad++;
        $display("FAIL toggle_acquire beats=%0d: got lock=%b valid=%b data=%h, want lock=%b valid=%b data=%h",
                 n, lock_v_o, valid_o, data_o, n == SH_CNT_MAX, v && n == SH_CNT_MAX, m_data);
      end
    end
  endtask

  task automatic test_reset_slip_wait();
    apply_reset();
    step(1, 2'b11, rnd64());
    step(1, legal_head(), rnd64());
    reset = 1'b1;
    step(1, illegal_head(), rnd64());
    reset = 1'b0;
    total++;
    if ({slip_v_o, lock_v_o, valid_o, head_o, data_o} !== '0) begin
      bad++;
      $display("FAIL reset_in_wait: got slip=%b lock=%b valid=%b head=%b data=%h, want all 0",
               slip_v_o, lock_v_o, valid_o, head_o, data_o);
    end
    for (int i = 1; i <= SH_CNT_MAX; i++) begin
      step(1, legal_head(), rnd64());
      total++;
      if (lock_v_o !== (i == SH_CNT_MAX) || slip_v_o !== 1'b0) begin
        bad++;
        $display("FAIL reset_wait_relock beat %0d: got lock=%b slip=%b, want lock=%b slip=0",
                 i, lock_v_o, slip_v_o, i == SH_CNT_MAX);
      end
    end
  endtask

  task automatic test_random();
    int rate = 0;
    int last_slip = -100;
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) rate = (c / 400 % 3 == 0) ? 0 : ((c / 400 % 3 == 1) ? 1 : 20);
      pma = ($urandom_range(0, 199) != 0);
      step($urandom_range(0, 9) < 8,
           ($urandom_range(0, 99) < rate) ? illegal_head() : legal_head(), rnd64());
      total++;
      if (lock_v_o !== m_lock || slip_v_o !== m_slip || valid_o !== m_valid ||
          head_o !== m_head || data_o !== m_data) begin
        bad++;
        $display("FAIL random cyc %0d: got lock=%b slip=%b valid=%b head=%b data=%h, want %b %b %b %b %h",
                 c, lock_v_o, slip_v_o, valid_o, head_o, data_o, m_lock, m_slip, m_valid, m_head, m_data);
      end
      if (slip_v_o) begin
        total++;
        if (lock_v_o || (c - last_slip) < SLIP_WAIT + 1) begin
          bad++;
          $display("FAIL slip_rules cyc %0d: got lock=%b gap=%0d, want lock=0 gap>=%0d",
                   c, lock_v_o, c - last_slip, SLIP_WAIT + 1);
        end
        last_slip = c;
      end
    end
    pma = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_slip();
    test_window();
    test_pma();
    test_toggle();
    test_reset_slip_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
